// File: rtl/shift_register_pkg.sv
// rtl/shift_register_pkg.sv - shared state encoding and counter sizing for the shift register controller
package shift_register_pkg;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  // Counter width that still gives one bit when the count range collapses to a single value.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/piso_stream_ctrl_if.sv
// rtl/piso_stream_ctrl_if.sv - word stream in, shift register control out
interface piso_stream_ctrl_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] data_i;
  logic             valid_i;
  logic             ready_o;
  logic             set_o;
  logic [WIDTH-1:0] value_o;
  logic             advance_o;
  logic             busy_o;
  logic             done_o;

  modport master (
    output data_i, valid_i,
    input  ready_o, set_o, value_o, advance_o, busy_o, done_o
  );

  modport slave (
    input  data_i, valid_i,
    output ready_o, set_o, value_o, advance_o, busy_o, done_o
  );

endinterface

// File: rtl/bit_tick_divider.sv
// rtl/bit_tick_divider.sv - counts clocks within one serial bit and flags the last one
module bit_tick_divider
  import shift_register_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clear_i,
  output logic last_cyc_o
);

  localparam int              CW   = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0]   LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] div_cnt_q;
  logic [CW-1:0] div_cnt_d;

  assign last_cyc_o = (div_cnt_q == LAST);

  always_comb begin
    div_cnt_d = div_cnt_q;
    if (clear_i) begin
      div_cnt_d = '0;
    end else if (en_i) begin
      div_cnt_d = last_cyc_o ? '0 : div_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/piso_stream_ctrl.sv
// rtl/piso_stream_ctrl.sv - paces a PISO shift register from a valid/ready word stream, LSB first
module piso_stream_ctrl
  import shift_register_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  piso_stream_ctrl_if.slave   bus
);

  localparam int            BW       = cnt_width(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  logic [0:0]    state_q;
  logic [0:0]    state_d;
  logic [BW-1:0] bit_cnt_q;
  logic [BW-1:0] bit_cnt_d;

  logic in_shift;
  logic last_cyc;
  logic last_bit;
  logic frame_end;
  logic ready;
  logic accept;

  bit_tick_divider #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_div (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .en_i       (in_shift),
    .clear_i    (accept),
    .last_cyc_o (last_cyc)
  );

  assign in_shift  = (state_q == SHIFT);
  assign last_bit  = (bit_cnt_q == LAST_BIT);
  assign frame_end = in_shift && last_cyc && last_bit;
  // The final cycle of a frame doubles as the load slot for the next word.
  assign ready     = !in_shift || frame_end;
  assign accept    = bus.valid_i && ready;

  assign bus.ready_o   = ready;
  assign bus.set_o     = accept;
  assign bus.value_o   = bus.data_i;
  assign bus.advance_o = in_shift && last_cyc && !last_bit;
  assign bus.busy_o    = in_shift;
  assign bus.done_o    = frame_end;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    if (accept) begin
      state_d   = SHIFT;
      bit_cnt_d = '0;
    end else if (frame_end) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
    end else if (in_shift && last_cyc) begin
      bit_cnt_d = bit_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

endmodule

// File: tb/tb_piso_stream_ctrl.sv
// tb/tb_piso_stream_ctrl.sv - directed and random checks of piso_stream_ctrl at CLKS_PER_BIT 4 and 1
module tb_piso_stream_ctrl;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic run_chk = 1'b0;
  logic [W-1:0] data;
  logic valid;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  piso_stream_ctrl_if #(.WIDTH(W)) bus4 ();
  piso_stream_ctrl_if #(.WIDTH(W)) bus1 ();

  piso_stream_ctrl #(.WIDTH(W), .CLKS_PER_BIT(4)) u4 (.clk_i(clk), .rst_ni(rst_n), .bus(bus4.slave));
  piso_stream_ctrl #(.WIDTH(W), .CLKS_PER_BIT(1)) u1 (.clk_i(clk), .rst_ni(rst_n), .bus(bus1.slave));

  assign bus4.data_i  = data;
  assign bus4.valid_i = valid;
  assign bus1.data_i  = data;
  assign bus1.valid_i = valid;

  logic rdy [2], set [2], adv [2], busy [2], done [2];
  logic [W-1:0] val [2];
  assign rdy[0] = bus4.ready_o;  assign rdy[1] = bus1.ready_o;
  assign set[0] = bus4.set_o;    assign set[1] = bus1.set_o;
  assign adv[0] = bus4.advance_o; assign adv[1] = bus1.advance_o;
  assign busy[0] = bus4.busy_o;  assign busy[1] = bus1.busy_o;
  assign done[0] = bus4.done_o;  assign done[1] = bus1.done_o;
  assign val[0] = bus4.value_o;  assign val[1] = bus1.value_o;

  function automatic int cpb(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  // Behavioural shift register the controller drives.
  logic [W-1:0] sr [2];
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (set[i]) sr[i] <= val[i];
      else if (adv[i]) sr[i] <= sr[i] >> 1;
    end
  end

  // Reference: position within the frame in clocks; bit index and pacing follow by division.
  logic         m_act  [2];
  int           m_pos  [2];
  logic [W-1:0] m_word [2];

  function automatic logic e_done(input int i);
    return m_act[i] && (m_pos[i] == W * cpb(i) - 1);
  endfunction
  function automatic logic e_ready(input int i);
    return !m_act[i] || e_done(i);
  endfunction
  function automatic logic e_adv(input int i);
    return m_act[i] && (m_pos[i] % cpb(i) == cpb(i) - 1) && (m_pos[i] / cpb(i) != W - 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_act[i] <= 1'b0;
        m_pos[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (valid && e_ready(i)) begin
          m_act[i]  <= 1'b1;
          m_pos[i]  <= 0;
          m_word[i] <= data;
        end else if (e_done(i)) begin
          m_act[i] <= 1'b0;
        end else if (m_act[i]) begin
          m_pos[i] <= m_pos[i] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (run_chk) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("c%0d_ready", cpb(i)), rdy[i], e_ready(i));
        chk($sformatf("c%0d_set", cpb(i)), set[i], valid && e_ready(i));
        chk($sformatf("c%0d_value", cpb(i)), val[i], data);
        chk($sformatf("c%0d_advance", cpb(i)), adv[i], e_adv(i));
        chk($sformatf("c%0d_busy", cpb(i)), busy[i], m_act[i]);
        chk($sformatf("c%0d_done", cpb(i)), done[i], e_done(i));
        if (m_act[i]) chk($sformatf("c%0d_bit", cpb(i)), sr[i][0], m_word[i][m_pos[i] / cpb(i)]);
      end
    end
  end

  task automatic send(input logic [W-1:0] d);
    int n;
    @(posedge clk); #1;
    data = d;
    valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!set[0] && n < 300);
    if (!set[0]) chk("send_accept_timeout", 0, 1);
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic measure(input int i, output int busy_cnt, output int adv_cnt,
                         output int done_cnt, output int done_at, output logic [W-1:0] word);
    int idx;
    busy_cnt = 0; adv_cnt = 0; done_cnt = 0; done_at = 0; word = '0; idx = 0;
    for (int c = 0; c < W * cpb(i) + 8; c++) begin
      @(negedge clk);
      if (busy[i]) begin
        idx++;
        busy_cnt++;
        if ((idx - 1) % cpb(i) == cpb(i) / 2 && idx <= W * cpb(i)) word[(idx - 1) / cpb(i)] = sr[i][0];
      end
      if (adv[i]) adv_cnt++;
      if (done[i]) begin
        done_cnt++;
        done_at = idx;
      end
    end
  endtask

  initial begin
    int bc, ac, dc, da, idx, run, maxrun;
    logic [W-1:0] wd;
    logic [15:0] stream;
    logic [7:0] adv_mask, rdy_mask;
    logic second_seen, drop;

    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc, ac, dc, da, idx, run, maxrun, ok;
    logic [W-1:0] wd;
    logic [15:0] stream;
    logic [7:0] adv_mask, rdy_mask;
    logic drop;

    valid = 1'b0;
    data = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    run_chk = 1'b1;

    @(negedge clk);
    chk("reset_ready", rdy[0], 1);
    chk("reset_busy", busy[0], 0);

    // Single word A5.
    send(8'hA5);
    measure(0, bc, ac, dc, da, wd);
    chk("a5_busy_cycles", bc, 32);
    chk("a5_advance_pulses", ac, 7);
    chk("a5_done_pulses", dc, 1);
    chk("a5_done_cycle", da, 32);
    chk("a5_serial", wd, 8'hA5);

    // Back-to-back 3C then C3 with valid held.
    @(posedge clk); #1;
    data = 8'h3C;
    valid = 1'b1;
    idx = 0;
    do begin
      @(negedge clk);
      idx++;
    end while (!set[0] && idx < 300);
    @(posedge clk); #1;
    data = 8'hC3;
    idx = 0; run = 0; maxrun = 0; stream = '0; drop = 1'b0;
    for (int c = 0; c < 72; c++) begin
      @(negedge clk);
      if (busy[0]) begin
        idx++;
        run++;
        if (run > maxrun) maxrun = run;
        if ((idx - 1) % 4 == 2 && idx <= 64) stream[(idx - 1) / 4] = sr[0][0];
      end else begin
        run = 0;
      end
      if (set[0] && valid) begin
        chk("b2b_set_on_done", done[0], 1);
        drop = 1'b1;
      end
      if (drop) begin
        @(posedge clk); #1;
        valid = 1'b0;
        drop = 1'b0;
      end
    end
    chk("b2b_busy_run", maxrun, 64);
    chk("b2b_serial", stream, 16'hC33C);

    // CLKS_PER_BIT=1 with FF.
    repeat (4) @(posedge clk);
    send(8'hFF);
    idx = 0; adv_mask = '0; rdy_mask = '0; da = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (busy[1]) begin
        idx++;
        if (idx <= 8) begin
          adv_mask[idx - 1] = adv[1];
          rdy_mask[idx - 1] = rdy[1];
        end
        if (done[1]) da = idx;
      end
    end
    chk("c1_advance_mask", adv_mask, 8'h7F);
    chk("c1_ready_mask", rdy_mask, 8'h80);
    chk("c1_done_cycle", da, 8);

    // Backpressure: 12 offered on the fifth cycle of a frame.
    repeat (30) @(posedge clk);
    send(8'h55);
    repeat (4) @(posedge clk);
    #1;
    data = 8'h12;
    valid = 1'b1;
    idx = 4;
    do begin
      @(negedge clk);
      idx++;
    end while (!set[0] && idx < 300);
    chk("bp_set_cycle", idx, 32);
    chk("bp_set_on_done", done[0], 1);
    @(posedge clk); #1;
    valid = 1'b0;
    measure(0, bc, ac, dc, da, wd);
    chk("bp_busy_cycles", bc, 32);
    chk("bp_serial", wd, 8'h12);

    // Reset at cycle 10 of a frame.
    send(8'h5A);
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", busy[0], 0);
    chk("rst_mid_advance", adv[0], 0);
    chk("rst_mid_done", done[0], 0);
    chk("rst_mid_ready", rdy[0], 1);
    @(negedge clk);
    #1 rst_n = 1'b1;
    send(8'h81);
    measure(0, bc, ac, dc, da, wd);
    chk("post_rst_busy_cycles", bc, 32);
    chk("post_rst_serial", wd, 8'h81);

    // Idle.
    ok = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (rdy[0] && !set[0] && !adv[0] && !busy[0]) ok++;
    end
    chk("idle_cycles_quiet", ok, 100);

    // Random traffic with occasional asynchronous reset pulses.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      valid = ($urandom_range(0, 2) != 0);
      data = W'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        #2 rst_n = 1'b0;
        #3 rst_n = 1'b1;
      end
    end
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (40) @(posedge clk);

    run_chk = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/piso_stream_ctrl.md
# piso_stream_ctrl

Upstream controller for the parallel-in serial-out shift register. Accepts WIDTH-bit words over a valid/ready stream, loads each word into the shift register and paces its shifting at one bit per CLKS_PER_BIT clocks, LSB first. Flags when the shift register's serial output carries a valid bit, and supports gapless back-to-back frames.

## Interface
- WIDTH, 8: word width; must match the shift register; ≥2.
- CLKS_PER_BIT, 4: clocks each serial bit is held; ≥1.
- clk_i  input  1  system clock.
- rst_ni  input  1  asynchronous, active-low reset.
- data_i  input  WIDTH  word to serialize.
- valid_i  input  1  data_i valid.
- ready_o  output  1  controller can accept a word this cycle.
- set_o  output  1  to shift register set_i; loads value_o.
- value_o  output  WIDTH  to shift register value_i.
- advance_o  output  1  to shift register advance_i.
- busy_o  output  1  shift register bit_o carries a valid data bit this cycle.
- done_o  output  1  one-cycle pulse on the final cycle of each frame.

## Operation
- States: IDLE, SHIFT. Counters: div_cnt (0..CLKS_PER_BIT-1), bit_cnt (0..WIDTH-1), each $clog2 width with a minimum of 1 bit.
- Accept = valid_i && ready_o. set_o = accept (combinational). value_o = data_i (pass-through).
- IDLE: ready_o=1, busy_o=0, advance_o=0. On accept go to SHIFT with div_cnt=0 and bit_cnt=0.
- SHIFT: busy_o=1; div_cnt increments each cycle and wraps at CLKS_PER_BIT-1.
- last_cyc = div_cnt==CLKS_PER_BIT-1. last_bit = bit_cnt==WIDTH-1.
- advance_o = SHIFT && last_cyc && !last_bit. bit_cnt increments on the same cycle.
- On last_cyc && last_bit, done_o=1 and ready_o=1. With accept, stay in SHIFT with both counters cleared (gapless). Without accept, go to IDLE.
- ready_o=0 on every other SHIFT cycle. valid_i with ready_o=0 is ignored; the source holds data_i.
- set_o and advance_o are never both high.
- CLKS_PER_BIT=1: last_cyc is always true; advance_o is high every SHIFT cycle except the final bit.

## Timing
- Reset (rst_ni low, asynchronous): state=IDLE, counters=0. Outputs are then ready_o=1 and busy_o=0, with advance_o, done_o and set_o low unless valid_i is high.
- Reset mid-frame aborts immediately; the partial frame is dropped. Shift register contents become don't-care, marked by busy_o=0. The next accept reloads the shift register.
- Accept at edge N: bit 0 appears on the shift register bit_o and busy_o rises in cycle N+1.
- Bit k is valid for cycles N+1+k·CLKS_PER_BIT through N+(k+1)·CLKS_PER_BIT.
- Frame length: WIDTH·CLKS_PER_BIT cycles of busy_o=1. done_o is high in the last of them.
- Back-to-back: bit 0 of the next word follows the last bit of the previous one on the next cycle, with no gap in busy_o.
- Throughput: one word per WIDTH·CLKS_PER_BIT cycles maximum.

## Structure
- Shared package shift_register_pkg holds:
  - state encoding localparams (IDLE=1'b0, SHIFT=1'b1);
  - the counter-width function (clog2 with a minimum of 1).
- Natural sub-module: bit_tick_divider. It holds the div_cnt counter, outputs last_cyc, and is cleared on accept.
- Integration wrapper (outside this block) connects set_o, value_o and advance_o to the shift register. It drives the shift register's rst_i from a synchronized !rst_ni.

## Test plan
- Reset then single word, WIDTH=8, CLKS_PER_BIT=4, data_i=8'hA5:
  - busy_o high for exactly 32 cycles;
  - bit_o sampled mid-bit reads 1,0,1,0,0,1,0,1;
  - done_o pulses once, on cycle 32;
  - advance_o pulses 7 times.
- Back-to-back, valid_i held high with words 8'h3C then 8'hC3:
  - second set_o coincides with the first done_o;
  - busy_o stays high for 64 continuous cycles;
  - serial stream is 0,0,1,1,1,1,0,0 followed by 1,1,0,0,0,0,1,1.
- CLKS_PER_BIT=1, data_i=8'hFF: advance_o high for 7 consecutive cycles, low on the 8th; done_o is on cycle 8; ready_o is low on cycles 1–7.
- Backpressure: valid_i asserted on SHIFT cycle 5 with data_i=8'h12 and held:
  - no set_o until the last frame cycle;
  - 8'h12 is then accepted and transmitted intact.
- Reset pulse at cycle 10 of a frame:
  - busy_o, advance_o and done_o drop immediately and ready_o=1;
  - the next accept of 8'h81 produces a full 32-cycle frame reading 1,0,0,0,0,0,0,1.
- Idle with valid_i=0: ready_o stays 1; set_o, advance_o and busy_o stay 0 for 100 cycles.
